// File: rtl/scram_pkg.sv
// Shared types and limits for the simple dual-port scratch RAM.
package scram_pkg;

    typedef enum logic {S_INIT, S_READY} scram_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/scram_sdp_if.sv
// Write/read port bundle for scram_sdp; the RAM is the slave side.
interface scram_sdp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);

    logic              init_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        input  init_done,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        output init_done,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );

endinterface

// File: rtl/scram_init_seq.sv
// Post-reset sweep: walks every address once, then parks in READY.
module scram_init_seq
    import scram_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_done
);

    scram_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and sweep write strobe; the last address is written on the leaving edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we   = 1'b0;
        init_addr = cnt_q;
        init_done = 1'b0;
        case (state_q)
            S_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                init_done = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

endmodule

// File: rtl/scram_sdp.sv
// Simple dual-port RAM with post-reset fill, 1- or 2-cycle read latency and
// selectable same-address read-during-write result.
module scram_sdp
    import scram_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              ADDR_W     = 2,
    parameter int              RD_LAT     = 1,
    parameter int              BYPASS     = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    scram_sdp_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("scram_sdp: RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              init_done;

    logic              wr_acc;
    logic              rd_acc;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_word;

    logic [1:0]        vld_q;
    logic [DATA_W-1:0] dat1_q;
    logic [DATA_W-1:0] dat2_q;

    scram_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_done (init_done)
    );

    // User traffic is dropped until the sweep has finished.
    assign wr_acc = init_done & bus.wr_en;
    assign rd_acc = init_done & bus.rd_en;

    assign we    = init_we | wr_acc;
    assign waddr = init_we ? init_addr  : bus.wr_addr;
    assign wdata = init_we ? INIT_VALUE : bus.wr_data;

    // Array read sees pre-edge contents; forwarding covers the BYPASS=1 collision case.
    assign rd_word = ((BYPASS != 0) && wr_acc && (bus.wr_addr == bus.rd_addr))
                   ? bus.wr_data : mem_q[bus.rd_addr];

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read pipeline: data registers only load with their valid so rd_data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            dat1_q <= '0;
            dat2_q <= '0;
        end else begin
            vld_q <= {vld_q[0], rd_acc};
            if (rd_acc) begin
                dat1_q <= rd_word;
            end
            if (vld_q[0]) begin
                dat2_q <= dat1_q;
            end
        end
    end

    assign bus.rd_valid  = (RD_LAT == 2) ? vld_q[1] : vld_q[0];
    assign bus.rd_data   = (RD_LAT == 2) ? dat2_q   : dat1_q;
    assign bus.init_done = init_done;

endmodule
